// File: rtl/mips_decode_stage.sv
// mips_decode_stage
//
// Registered MIPS instruction-decode stage. Each instruction from fetch is
// decoded combinationally into a one-hot operation vector, its register and
// shift fields, an extended immediate and the jump target. The decoded word
// and its PC are pushed into a small FIFO, so stalls on the fetch side and on
// the execute side are decoupled by valid/ready handshakes.
//
// Compile-time option:
//   MIPS_DECODE_EXT_EN  when defined, also decode NOR, XOR, SLL, SRL, BNE,
//                       ANDI, ORI and LUI (out_op bits 12-19). When undefined,
//                       those encodings are reported as illegal.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   flush               drop every buffered entry and the current input
//   in_valid/in_ready   fetch-side handshake
//   in_instr, in_pc     instruction word and its PC
//   out_valid/out_ready consumer-side handshake for the head entry
//   out_op              one-hot operation of the head entry (0 if illegal)
//   out_illegal         head entry is not a supported encoding
//   out_rs/rt/rd/shamt  instruction fields of the head entry
//   out_imm             extended immediate of the head entry
//   out_target          26-bit jump target field of the head entry
//   out_pc              PC of the head entry
//   illegal_count       saturating count of accepted illegal instructions
//
// FIFO state | meaning
// EMPTY      | no buffered entries, out_valid low
// PARTIAL    | at least one entry, room for more
// FULL       | DEPTH entries buffered, in_ready low

module mips_decode_stage #(
    parameter int PC_W   = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [19:0]       out_op,
    output logic              out_illegal,
    output logic [4:0]        out_rs,
    output logic [4:0]        out_rt,
    output logic [4:0]        out_rd,
    output logic [4:0]        out_shamt,
    output logic [DATA_W-1:0] out_imm,
    output logic [25:0]       out_target,
    output logic [PC_W-1:0]   out_pc,
    output logic [CNT_W-1:0]  illegal_count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int OCC_W   = PTR_W + 1;
    localparam int ENTRY_W = 20 + 1 + 20 + DATA_W + 26 + PC_W;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } fifo_state_t;

    // ------------------------------------------------------------------
    // Combinational decode of the incoming instruction
    // ------------------------------------------------------------------
    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [19:0]       dec_op;
    logic              dec_illegal;
    logic [DATA_W-1:0] dec_imm;
    logic [DATA_W-1:0] imm_sext;

    assign opcode   = in_instr[31:26];
    assign funct    = in_instr[5:0];
    assign imm_sext = DATA_W'($signed(in_instr[15:0]));

    always_comb begin
        dec_op  = '0;
        dec_imm = '0;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h20: dec_op[0] = 1'b1;
                    6'h22: dec_op[1] = 1'b1;
                    6'h24: dec_op[2] = 1'b1;
                    6'h25: dec_op[3] = 1'b1;
                    6'h2A: dec_op[4] = 1'b1;
                    6'h18: dec_op[5] = 1'b1;
`ifdef MIPS_DECODE_EXT_EN
                    6'h27: dec_op[12] = 1'b1;
                    6'h26: dec_op[13] = 1'b1;
                    6'h00: dec_op[14] = 1'b1;
                    6'h02: dec_op[15] = 1'b1;
`endif
                    default: ;
                endcase
            end
            6'h08: begin dec_op[6]  = 1'b1; dec_imm = imm_sext; end
            6'h09: begin dec_op[7]  = 1'b1; dec_imm = imm_sext; end
            6'h23: begin dec_op[8]  = 1'b1; dec_imm = imm_sext; end
            6'h2B: begin dec_op[9]  = 1'b1; dec_imm = imm_sext; end
            6'h04: begin dec_op[10] = 1'b1; dec_imm = imm_sext; end
            6'h02: dec_op[11] = 1'b1;
`ifdef MIPS_DECODE_EXT_EN
            6'h05: begin dec_op[16] = 1'b1; dec_imm = imm_sext; end
            6'h0C: begin dec_op[17] = 1'b1; dec_imm = DATA_W'(in_instr[15:0]); end
            6'h0D: begin dec_op[18] = 1'b1; dec_imm = DATA_W'(in_instr[15:0]); end
            6'h0F: begin dec_op[19] = 1'b1; dec_imm = DATA_W'({in_instr[15:0], 16'h0000}); end
`endif
            default: ;
        endcase
    end

    assign dec_illegal = ~|dec_op;

    // ------------------------------------------------------------------
    // Decoded-entry FIFO
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] head;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [OCC_W-1:0]   occ;
    logic [OCC_W-1:0]   occ_next;
    fifo_state_t        state;
    logic               push;
    logic               pop;

    assign wr_entry = {dec_op, dec_illegal, in_instr[25:21], in_instr[20:16],
                       in_instr[15:11], in_instr[10:6], dec_imm,
                       in_instr[25:0], in_pc};

    // in_ready comes only from registered state (and rst), never from out_ready.
    assign in_ready  = !rst && (state != FULL);
    assign out_valid = (state != EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        occ_next = occ;
        case ({push, pop})
            2'b10:   occ_next = occ + 1'b1;
            2'b01:   occ_next = occ - 1'b1;
            default: occ_next = occ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            occ           <= '0;
            state         <= EMPTY;
            illegal_count <= '0;
        end else begin
            // Counted even when the same-cycle flush drops the entry.
            if (push && dec_illegal && (illegal_count != {CNT_W{1'b1}}))
                illegal_count <= illegal_count + 1'b1;

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                occ    <= '0;
                state  <= EMPTY;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                occ <= occ_next;
                if (occ_next == '0)
                    state <= EMPTY;
                else if (occ_next == OCC_W'(DEPTH))
                    state <= FULL;
                else
                    state <= PARTIAL;
            end
        end
    end

    // Storage needs no reset: outputs are gated by out_valid.
    always_ff @(posedge clk) begin
        if (!rst && !flush && push)
            mem[wr_ptr] <= wr_entry;
    end

    assign head = out_valid ? mem[rd_ptr] : '0;
    assign {out_op, out_illegal, out_rs, out_rt, out_rd, out_shamt,
            out_imm, out_target, out_pc} = head;

endmodule

// File: tb/tb_mips_decode_stage.sv
module tb_mips_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_op;
    logic        out_illegal;
    logic [4:0]  out_rs;
    logic [4:0]  out_rt;
    logic [4:0]  out_rd;
    logic [4:0]  out_shamt;
    logic [31:0] out_imm;
    logic [25:0] out_target;
    logic [31:0] out_pc;
    logic [1:0]  illegal_count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    mips_decode_stage #(
        .PC_W(32), .DATA_W(32), .DEPTH(2), .CNT_W(2)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_illegal(out_illegal),
        .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd), .out_shamt(out_shamt),
        .out_imm(out_imm), .out_target(out_target), .out_pc(out_pc),
        .illegal_count(illegal_count)
    );

    always #5 clk = ~clk;

    task tick;
        @(posedge clk);
        #1;
    endtask

    task push(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        tick();
        in_valid = 1'b0;
    endtask

    task do_reset;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task test_reset;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = 32'h0; in_pc = 32'h0;
        tick();
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL reset_in_ready_hi: got %0b exp 0", in_ready);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({out_valid, out_op, out_illegal, illegal_count} !== 24'h0)
            $display("FAIL reset_outputs: got v=%0b op=%0h ill=%0b cnt=%0d exp all 0",
                     out_valid, out_op, out_illegal, illegal_count);
        else pass_cnt++;
        total_cnt++;
        if ({out_rs, out_rt, out_rd, out_shamt, out_imm, out_target, out_pc} !== 110'h0)
            $display("FAIL reset_fields: got rs=%0h rt=%0h rd=%0h imm=%0h pc=%0h exp 0",
                     out_rs, out_rt, out_rd, out_imm, out_pc);
        else pass_cnt++;
        rst = 1'b0;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready_after: got %0b exp 1", in_ready);
        else pass_cnt++;
    endtask

    task test_add;
        out_ready = 1'b1;
        push(32'h00851020, 32'h0000_0100);
        total_cnt++;
        if ({out_valid, out_op, out_illegal} !== {1'b1, 20'h00001, 1'b0})
            $display("FAIL add_op: got v=%0b op=%0h ill=%0b exp v=1 op=1 ill=0",
                     out_valid, out_op, out_illegal);
        else pass_cnt++;
        total_cnt++;
        if ({out_rs, out_rt, out_rd, out_pc, illegal_count} !== {5'd4, 5'd5, 5'd2, 32'h100, 2'd0})
            $display("FAIL add_fields: got rs=%0d rt=%0d rd=%0d pc=%0h cnt=%0d exp 4 5 2 100 0",
                     out_rs, out_rt, out_rd, out_pc, illegal_count);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL add_drained: got %0b exp 0", out_valid);
        else pass_cnt++;
    endtask

    // Sustained 1/cycle with out_ready high: each accept appears the next cycle.
    task test_back_to_back;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h2008FFFF; in_pc = 32'h10;
        tick();
        total_cnt++;
        if ({out_valid, out_op, out_rt, out_imm, out_pc} !== {1'b1, 20'h00040, 5'd8, 32'hFFFF_FFFF, 32'h10})
            $display("FAIL b2b_addi: got v=%0b op=%0h rt=%0d imm=%0h pc=%0h exp 1 40 8 ffffffff 10",
                     out_valid, out_op, out_rt, out_imm, out_pc);
        else pass_cnt++;
        in_instr = 32'h8C220004; in_pc = 32'h14;
        tick();
        total_cnt++;
        if ({out_valid, out_op, out_rs, out_rt, out_imm, out_pc} !== {1'b1, 20'h00100, 5'd1, 5'd2, 32'h4, 32'h14})
            $display("FAIL b2b_lw: got v=%0b op=%0h rs=%0d rt=%0d imm=%0h pc=%0h exp 1 100 1 2 4 14",
                     out_valid, out_op, out_rs, out_rt, out_imm, out_pc);
        else pass_cnt++;
        in_instr = 32'h1022FFFE; in_pc = 32'h18;
        tick();
        total_cnt++;
        if ({out_valid, out_op, out_imm} !== {1'b1, 20'h00400, 32'hFFFF_FFFE})
            $display("FAIL b2b_beq: got v=%0b op=%0h imm=%0h exp 1 400 fffffffe",
                     out_valid, out_op, out_imm);
        else pass_cnt++;
        in_instr = 32'h08000040; in_pc = 32'h1C;
        tick();
        total_cnt++;
        if ({out_valid, out_op, out_target, out_imm} !== {1'b1, 20'h00800, 26'h40, 32'h0})
            $display("FAIL b2b_j: got v=%0b op=%0h tgt=%0h imm=%0h exp 1 800 40 0",
                     out_valid, out_op, out_target, out_imm);
        else pass_cnt++;
        in_instr = 32'hAC220008; in_pc = 32'h20;
        tick();
        total_cnt++;
        if ({out_valid, out_op, out_imm} !== {1'b1, 20'h00200, 32'h8})
            $display("FAIL b2b_sw: got v=%0b op=%0h imm=%0h exp 1 200 8", out_valid, out_op, out_imm);
        else pass_cnt++;
        in_valid = 1'b0;
        tick();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL b2b_empty: got %0b exp 0", out_valid);
        else pass_cnt++;
    endtask

    task test_backpressure;
        out_ready = 1'b0;
        push(32'h00851022, 32'h200);
        total_cnt++;
        if ({in_ready, out_valid, out_op} !== {1'b1, 1'b1, 20'h00002})
            $display("FAIL bp_first: got rdy=%0b v=%0b op=%0h exp 1 1 2", in_ready, out_valid, out_op);
        else pass_cnt++;
        push(32'h00851025, 32'h204);
        total_cnt++;
        if ({in_ready, out_op, out_pc} !== {1'b0, 20'h00002, 32'h200})
            $display("FAIL bp_full: got rdy=%0b op=%0h pc=%0h exp 0 2 200", in_ready, out_op, out_pc);
        else pass_cnt++;
        in_valid = 1'b1; in_instr = 32'h00851024; in_pc = 32'h208;
        tick();
        total_cnt++;
        if ({in_ready, out_valid, out_op, out_pc} !== {1'b0, 1'b1, 20'h00002, 32'h200})
            $display("FAIL bp_hold: got rdy=%0b v=%0b op=%0h pc=%0h exp 0 1 2 200",
                     in_ready, out_valid, out_op, out_pc);
        else pass_cnt++;
        out_ready = 1'b1;
        tick();
        total_cnt++;
        if ({in_ready, out_op, out_pc} !== {1'b1, 20'h00008, 32'h204})
            $display("FAIL bp_drain1: got rdy=%0b op=%0h pc=%0h exp 1 8 204", in_ready, out_op, out_pc);
        else pass_cnt++;
        tick();
        in_valid = 1'b0;
        total_cnt++;
        if ({out_valid, out_op, out_pc} !== {1'b1, 20'h00004, 32'h208})
            $display("FAIL bp_drain2: got v=%0b op=%0h pc=%0h exp 1 4 208", out_valid, out_op, out_pc);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL bp_empty: got %0b exp 0", out_valid);
        else pass_cnt++;
    endtask

    task test_illegal;
        out_ready = 1'b1;
        push(32'hFC000000, 32'h300);
        total_cnt++;
        if ({out_valid, out_illegal, out_op, illegal_count} !== {1'b1, 1'b1, 20'h0, 2'd1})
            $display("FAIL illegal: got v=%0b ill=%0b op=%0h cnt=%0d exp 1 1 0 1",
                     out_valid, out_illegal, out_op, illegal_count);
        else pass_cnt++;
        push(32'h00850018, 32'h304);
    endtask

    task test_ext;
        out_ready = 1'b1;
`ifdef MIPS_DECODE_EXT_EN
        push(32'h3C011234, 32'h400);
        total_cnt++;
        if ({out_illegal, out_op, out_imm, illegal_count} !== {1'b0, 20'h80000, 32'h1234_0000, 2'd1})
            $display("FAIL ext_lui: got ill=%0b op=%0h imm=%0h cnt=%0d exp 0 80000 12340000 1",
                     out_illegal, out_op, out_imm, illegal_count);
        else pass_cnt++;
        push(32'h34A5F0F0, 32'h404);
        total_cnt++;
        if ({out_illegal, out_op, out_imm} !== {1'b0, 20'h40000, 32'h0000_F0F0})
            $display("FAIL ext_ori: got ill=%0b op=%0h imm=%0h exp 0 40000 f0f0",
                     out_illegal, out_op, out_imm);
        else pass_cnt++;
        push(32'h00851027, 32'h408);
        total_cnt++;
        if ({out_illegal, out_op, illegal_count} !== {1'b0, 20'h01000, 2'd1})
            $display("FAIL ext_nor: got ill=%0b op=%0h cnt=%0d exp 0 1000 1",
                     out_illegal, out_op, illegal_count);
        else pass_cnt++;
`else
        push(32'h00851027, 32'h400);
        total_cnt++;
        if ({out_illegal, out_op, illegal_count} !== {1'b1, 20'h0, 2'd2})
            $display("FAIL noext_nor: got ill=%0b op=%0h cnt=%0d exp 1 0 2",
                     out_illegal, out_op, illegal_count);
        else pass_cnt++;
        push(32'h3C011234, 32'h404);
        total_cnt++;
        if ({out_illegal, out_op, out_imm, illegal_count} !== {1'b1, 20'h0, 32'h0, 2'd3})
            $display("FAIL noext_lui: got ill=%0b op=%0h imm=%0h cnt=%0d exp 1 0 0 3",
                     out_illegal, out_op, out_imm, illegal_count);
        else pass_cnt++;
`endif
        tick();
    endtask

    task test_saturation;
        logic [1:0] exp_cnt;
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'hFC000000;
        in_pc     = 32'h500;
        for (int i = 0; i < 5; i++) begin
            tick();
            exp_cnt = (i < 3) ? 2'(i + 1) : 2'd3;
            total_cnt++;
            if (illegal_count !== exp_cnt)
                $display("FAIL sat_%0d: got cnt=%0d exp %0d", i, illegal_count, exp_cnt);
            else pass_cnt++;
        end
        in_valid = 1'b0;
        tick();
    endtask

    task test_flush;
        do_reset();
        out_ready = 1'b0;
        push(32'h00851020, 32'h600);
        push(32'h00851022, 32'h604);
        flush = 1'b1; in_valid = 1'b1; in_instr = 32'h08000040; in_pc = 32'h608;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        total_cnt++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL flush_full: got v=%0b rdy=%0b exp 0 1", out_valid, in_ready);
        else pass_cnt++;
        out_ready = 1'b1;
        tick();
        tick();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL flush_no_ghost: got %0b exp 0", out_valid);
        else pass_cnt++;
        // Illegal input accepted in a flush cycle: dropped but counted.
        out_ready = 1'b0;
        push(32'h0085102A, 32'h610);
        flush = 1'b1; in_valid = 1'b1; in_instr = 32'hFC000000; in_pc = 32'h614;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        total_cnt++;
        if ({out_valid, illegal_count} !== {1'b0, 2'd1})
            $display("FAIL flush_count: got v=%0b cnt=%0d exp 0 1", out_valid, illegal_count);
        else pass_cnt++;
        // After flush, a fresh push comes out cleanly from the reset pointers.
        out_ready = 1'b1;
        push(32'h00850018, 32'h618);
        total_cnt++;
        if ({out_valid, out_op, out_pc} !== {1'b1, 20'h00020, 32'h618})
            $display("FAIL flush_resume: got v=%0b op=%0h pc=%0h exp 1 20 618", out_valid, out_op, out_pc);
        else pass_cnt++;
        tick();
    endtask

    task test_reset_midstream;
        do_reset();
        out_ready = 1'b0;
        push(32'hFC000000, 32'h700);
        push(32'h00851020, 32'h704);
        rst = 1'b1; flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        in_instr = 32'hFC000000;
        tick();
        total_cnt++;
        if ({out_valid, illegal_count, in_ready} !== {1'b0, 2'd0, 1'b0})
            $display("FAIL midstream_reset: got v=%0b cnt=%0d rdy=%0b exp 0 0 0",
                     out_valid, illegal_count, in_ready);
        else pass_cnt++;
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_backpressure();
        test_illegal();
        test_ext();
        test_saturation();
        test_flush();
        test_reset_midstream();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mips_decode_stage.md
# mips_decode_stage

Registered, buffered MIPS instruction-decode stage that sits between instruction fetch and register-file read in the pipelined MIPS datapath. It decodes 32-bit instructions into a one-hot operation vector plus extracted fields and an extended immediate, with a flag for illegal encodings. Decoded results are held in a small FIFO with valid/ready handshakes on both sides, so fetch and execute stalls are decoupled. An optional extended-ISA decode set is selectable at compile time.

## Interface
Parameters:
- PC_W, 32, width of the PC carried alongside each instruction
- DATA_W, 32, width of extended immediate (≥32)
- DEPTH, 2, decoded-entry buffer depth (power of 2, ≥2)
- CNT_W, 16, illegal-instruction counter width

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all buffered entries and the current input
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage can accept (buffer not full)
- in_instr  in  32  instruction word
- in_pc  in  PC_W  PC of instruction
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer takes head entry
- out_op  out  20  one-hot operation (index list below)
- out_illegal  out  1  head entry is not a supported encoding
- out_rs / out_rt / out_rd / out_shamt  out  5 each  instruction fields
- out_imm  out  DATA_W  extended immediate
- out_target  out  26  jump target field
- out_pc  out  PC_W  PC of head entry
- illegal_count  out  CNT_W  saturating count of accepted illegal instructions

## Operation
- out_op bits: 0 ADD (op 0x00, funct 0x20), 1 SUB (0x22), 2 AND (0x24), 3 OR (0x25), 4 SLT (0x2A), 5 MULT (0x18), 6 ADDI (op 0x08), 7 ADDIU (0x09), 8 LW (0x23), 9 SW (0x2B), 10 BEQ (0x04), 11 J (0x02); extended: 12 NOR (funct 0x27), 13 XOR (0x26), 14 SLL (0x00), 15 SRL (0x02), 16 BNE (op 0x05), 17 ANDI (0x0C), 18 ORI (0x0D), 19 LUI (0x0F).
- Exactly one out_op bit is set for a legal entry. An unmatched encoding gives out_op all-zero with out_illegal=1.
- Immediate: sign-extended from instr[15:0] for ADDI, ADDIU, LW, SW, BEQ, BNE; zero-extended for ANDI, ORI; LUI yields instr[15:0]<<16 zero-filled; all other ops give 0.
- Decode is combinational on the input; the decoded word plus PC is written into the FIFO on accept (in_valid && in_ready).
- Pop on out_valid && out_ready. Push and pop are allowed in the same cycle; occupancy is unchanged.
- FIFO states are EMPTY, PARTIAL and FULL, driven by the occupancy counter; read and write pointers wrap modulo DEPTH.
- illegal_count increments on each accepted illegal instruction and saturates at 2^CNT_W−1. Only rst clears it; flush does not.
- flush: the next cycle has occupancy 0 and out_valid=0. An input accepted in the flush cycle is dropped but still counted if illegal. Flush has priority over push and pop.

## Timing
- Reset values: out_valid=0, out_op=0, out_illegal=0, all field outputs 0, illegal_count=0. in_ready=0 while rst is high and 1 in the first cycle after.
- Latency: accept in cycle N gives out_valid=1 in cycle N+1 when the buffer was empty.
- Throughput: 1 instruction/cycle sustained when out_ready is held high.
- in_ready = (occupancy < DEPTH), registered-derived, with no combinational path from out_ready. When FULL, a same-cycle pop does not raise in_ready until the next cycle.
- Outputs hold stable while out_valid && !out_ready.
- Reset asserted mid-stream empties the buffer at the next edge, overriding flush, push and pop.

## Configuration
- MIPS_DECODE_EXT_EN defined: out_op bits 12–19 decode as listed.
- Not defined: bits 12–19 are tied 0, those encodings report out_illegal=1 and count as illegal, and ANDI/ORI/LUI immediate handling is absent (imm=0).

## Test plan
- Reset, then push ADD 0x00851020 with out_ready=1 -> next cycle out_valid=1, out_op=bit0, rs=4, rt=5, rd=2, illegal_count=0.
- Push ADDI 0x2008FFFF -> out_op=bit6, out_imm=0xFFFFFFFF. Push LUI 0x3C011234 (EXT_EN) -> out_op=bit19, out_imm=0x12340000.
- Hold out_ready=0 and push 3 instructions (DEPTH=2) -> in_ready drops after the 2nd accept, the 3rd is held, and order is preserved when draining.
- Push 0xFC000000 -> out_illegal=1, out_op=0, illegal_count=1. With CNT_W=2, push 5 illegals -> count saturates at 3.
- Fill the buffer, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, and no flushed entry ever appears.
- Without MIPS_DECODE_EXT_EN, push NOR 0x00851027 -> out_illegal=1 and illegal_count increments.
